gray_conv_pipe: RTL and testbench
=================================

# gray_conv_pipe

Parametrised, pipelined bidirectional binary/Gray code converter with a valid/ready stream interface. Each transfer carries a per-word mode bit selecting binary-to-Gray or Gray-to-binary conversion. The serial Gray-to-binary XOR chain is split across a configurable number of register stages, so wide words close timing. It sits between counter/pointer logic and clock-domain-crossing or encoder stages that need either code.

## Interface
- WIDTH, 8: data word width in bits; legal range is WIDTH ≥ 2.
- STAGES, 2: number of pipeline register stages, which equals the latency; legal range is 1 ≤ STAGES ≤ WIDTH.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset; deassertion must be synchronous to clk externally.
- clr  input  1  synchronous flush; when high, all stage valids are cleared on the next edge.
- in_valid  input  1  upstream word is present.
- in_ready  output  1  block accepts a word this cycle.
- in_data  input  WIDTH  word to convert.
- in_mode  input  1  0 = binary→Gray, 1 = Gray→binary.
- out_valid  output  1  converted word is present.
- out_ready  input  1  downstream accepts the word.
- out_data  output  WIDTH  converted word.
- out_mode  output  1  mode bit travelling with the word.

## Operation
- Binary→Gray: g[WIDTH-1] = b[WIDTH-1]; g[i] = b[i+1] ^ b[i]. Fully computed in stage 1, then carried unchanged through the remaining stages.
- Gray→binary: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i].
  - Let CH = ceil(WIDTH/STAGES). Stage s (1..STAGES) resolves bits WIDTH-1-(s-1)·CH down to max(0, WIDTH-s·CH), using the last resolved bit from stage s-1.
  - Unresolved bits travel as raw Gray bits.
  - Any stage whose range is empty acts as a pure register.
- Each stage holds a valid bit, the data word and the mode bit. A word's mode never changes in flight, and mixed modes may be interleaved freely.
- Stage advance rule: stage s loads when its valid = 0, or when stage s+1 loads that cycle. For the last stage, "stage s+1 loads" means out_ready = 1.
- in_ready = stage-1 load condition. This is combinational from out_ready through the stage valids. There is no combinational path from in_valid or in_data to out_*.
- A transfer happens on a cycle where valid && ready are both high. Words are never dropped, duplicated or reordered.
- While out_valid = 1 and out_ready = 0, out_data and out_mode hold stable.
- clr has priority over loads: every valid clears and the in-flight words are discarded. in_ready is still evaluated normally in that cycle, but the word presented is not captured. Data registers need not clear.

## Timing
- Reset (rst_n = 0, asynchronous) clears all stage valids to 0 and all data and mode registers to 0. During and after reset: out_valid = 0, out_data = 0, out_mode = 0, in_ready = 1.
- Latency: a word accepted at edge N appears on out_valid/out_data after edge N+STAGES-1, and is available to be consumed at edge N+STAGES, provided there is no stall.
- Throughput: one word per cycle when out_ready is held at 1.
- Full condition: all STAGES valids are 1 and out_ready = 0 → in_ready = 0.
- A bubble in any stage is filled even while the output stalls. Capacity is STAGES words.
- Simultaneous accept and emit with the pipeline full and out_ready = 1 → in_ready = 1 and occupancy is unchanged.
- If reset asserts mid-stream, in-flight words are lost. The first transfer after reset behaves exactly as after power-up.

## Test plan
- Both directions, WIDTH=8, STAGES=2, out_ready=1:
  - bin2gray 0x2D → 0x3B, 0xFF → 0x80, 0x00 → 0x00.
  - gray2bin 0x3B → 0x2D, 0x80 → 0xFF.
  - Each output appears 2 cycles after acceptance, with out_mode echoed.
- Interleaved modes, back-to-back: send 0x2D/m0, 0x3B/m1, 0xA5/m0, 0xF7/m1 on 4 consecutive cycles.
  - Required outputs on 4 consecutive cycles: 0x3B, 0x2D, 0xF7, 0xA5.
  - in_ready stays 1 throughout.
- Backpressure: hold out_ready=0 for 5 cycles while streaming 3 words.
  - in_ready drops after 2 accepts.
  - out_data holds the first result stably.
  - On release, the 3 words emerge in order, one per cycle, with no loss.
- Exhaustive round trip, WIDTH=8, for STAGES ∈ {1, 3, 8}:
  - All 256 values bin2gray then gray2bin return the original value.
  - Adjacent binary inputs yield Gray outputs differing in exactly one bit.
- Flush and reset: fill the pipeline, then pulse clr for 1 cycle → out_valid = 0 next cycle and no stale word ever emerges.
  - Repeat with rst_n pulsed low asynchronously mid-cycle → all outputs go to 0 immediately and in_ready = 1.
- WIDTH=13, STAGES=4 (CH=4, last stage resolves 1 bit): gray2bin 0x1FFF → 0x1555, bin2gray 0x1555 → 0x1FFF, with latency 4.

Source files
------------

// File: rtl/gray_conv_pipe.sv
`default_nettype none
// ============================================================================
// Module : gray_conv_pipe
// Brief  : Pipelined binary<->Gray converter, per-word mode, valid/ready flow.
// Rev    : 1.0  initial release
// ============================================================================
module gray_conv_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode
);

  localparam int CH = (WIDTH + STAGES - 1) / STAGES;

  logic [STAGES-1:0]            r_valid;
  logic [STAGES-1:0]            r_mode;
  logic [STAGES-1:0][WIDTH-1:0] r_data;

  logic [STAGES:0]              w_load;
  logic [STAGES-1:0]            w_src_valid;
  logic [STAGES-1:0]            w_src_mode;
  logic [STAGES-1:0][WIDTH-1:0] w_src_data;
  logic [STAGES-1:0][WIDTH-1:0] w_nxt_data;

  // A stage loads when empty or when the stage ahead of it loads this cycle.
  always_comb begin
    w_load         = '0;
    w_load[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_load[k] = ~r_valid[k] | w_load[k+1];
    end
  end

  assign in_ready = w_load[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Bit range of the Gray->binary chain resolved in this stage (empty if HI < 0).
    localparam int HI = WIDTH - 1 - k * CH;
    localparam int LO = (WIDTH - (k + 1) * CH > 0) ? (WIDTH - (k + 1) * CH) : 0;

    logic [WIDTH-1:0] w_nxt;

    if (k == 0) begin : g_head
      assign w_src_valid[k] = in_valid;
      assign w_src_mode[k]  = in_mode;
      assign w_src_data[k]  = in_data;
    end else begin : g_body
      assign w_src_valid[k] = r_valid[k-1];
      assign w_src_mode[k]  = r_mode[k-1];
      assign w_src_data[k]  = r_data[k-1];
    end

    always_comb begin
      w_nxt = w_src_data[k];
      if (!w_src_mode[k]) begin
        if (k == 0) begin
          w_nxt = w_src_data[k] ^ (w_src_data[k] >> 1);
        end
      end else begin
        // The MSB is its own binary value; each lower bit folds in the one above.
        for (int i = WIDTH - 2; i >= 0; i--) begin
          if (i <= HI && i >= LO) begin
            w_nxt[i] = w_nxt[i+1] ^ w_src_data[k][i];
          end
        end
      end
    end

    assign w_nxt_data[k] = w_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_mode  <= '0;
      r_data  <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (clr) begin
          r_valid[k] <= 1'b0;
        end else if (w_load[k]) begin
          r_valid[k] <= w_src_valid[k];
        end
        if (w_load[k] && w_src_valid[k]) begin
          r_data[k] <= w_nxt_data[k];
          r_mode[k] <= w_src_mode[k];
        end
      end
    end
  end

  assign out_valid = r_valid[STAGES-1];
  assign out_data  = r_data[STAGES-1];
  assign out_mode  = r_mode[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_gray_conv_pipe.sv
`default_nettype none
// Testbench for gray_conv_pipe: directed, randomized and exhaustive round-trip checks
// against a behavioural conversion model and an in-order scoreboard.
module tb_gray_conv_pipe;

  localparam int M_W  = 8;
  localparam int M_S  = 2;
  localparam int NCFG = 4;

  function automatic int cfg_w(input int i);
    return (i == 3) ? 13 : 8;
  endfunction

  function automatic int cfg_s(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      2:       return 8;
      default: return 4;
    endcase
  endfunction

  // Reference conversion from the code definitions, independent of staging.
  function automatic logic [15:0] model(input logic [15:0] x, input logic m, input int w);
    logic [15:0] r;
    logic        acc;
    r   = '0;
    acc = 1'b0;
    if (!m) begin
      r = x ^ (x >> 1);
    end else begin
      for (int i = w - 1; i >= 0; i--) begin
        acc  = acc ^ x[i];
        r[i] = acc;
      end
    end
    return r;
  endfunction

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, clr, in_valid, in_ready, in_mode, out_valid, out_ready, out_mode;
  logic [M_W-1:0] in_data, out_data;

  gray_conv_pipe #(.WIDTH(M_W), .STAGES(M_S)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode)
  );

  // ---------------- scoreboard / per-cycle compare for the main DUT ----------------
  logic [M_W:0] q[$];
  logic         prev_stall = 1'b0;
  logic [M_W:0] prev_word  = '0;

  always @(negedge clk) begin
    logic [15:0]  conv;
    logic [M_W:0] exp_w;
    if (!rst_n) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      check("in_ready", in_ready, (q.size() < M_S) || out_ready);
      if (prev_stall) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_word", {out_mode, out_data}, prev_word);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL spurious_out: got 0x%0h, expected no word", {out_mode, out_data});
        end else begin
          exp_w = q.pop_front();
          check("out_word", {out_mode, out_data}, exp_w);
        end
      end
      if (clr) begin
        q.delete();
      end else if (in_valid && in_ready) begin
        conv = model({8'h00, in_data}, in_mode, M_W);
        q.push_back({in_mode, conv[M_W-1:0]});
      end
      prev_stall = out_valid && !out_ready && !clr;
      prev_word  = {out_mode, out_data};
    end
  end

  // ---------------- directed burst helper (pipeline empty, out_ready=1) ----------------
  logic [M_W-1:0] bw_data [4];
  logic [M_W-1:0] bw_exp  [4];
  logic           bw_mode [4];

  task automatic run_burst(input int n, input string tag);
    logic           ov [8];
    logic [M_W-1:0] od [8];
    logic           om [8];
    out_ready = 1'b1;
    clr       = 1'b0;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          in_valid = 1'b1;
          in_data  = bw_data[i];
          in_mode  = bw_mode[i];
          @(negedge clk);
          check($sformatf("%s_in_ready%0d", tag, i), in_ready, 1'b1);
          @(posedge clk);
          #1;
        end
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < n + 4; c++) begin
          @(negedge clk);
          ov[c] = out_valid;
          od[c] = out_data;
          om[c] = out_mode;
        end
      end
    join
    for (int c = 0; c < n + 4; c++) begin
      check($sformatf("%s_valid_c%0d", tag, c), ov[c], (c >= M_S) && (c < M_S + n));
      if (c >= M_S && c < M_S + n) begin
        check($sformatf("%s_data_c%0d", tag, c), od[c], bw_exp[c-M_S]);
        check($sformatf("%s_mode_c%0d", tag, c), om[c], bw_mode[c-M_S]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- exhaustive round trip on other configurations ----------------
  logic            rt_go   = 1'b0;
  logic            rt_rst_n;
  logic [NCFG-1:0] rt_done;

  for (genvar gi = 0; gi < NCFG; gi++) begin : g_rt
    localparam int W = cfg_w(gi);
    localparam int S = cfg_s(gi);
    localparam int N = 1 << W;
    localparam logic [W-1:0] LIT = (W == 13) ? W'(16'h1555) : W'(16'h00AA);

    logic         v_in, r_in, v_out, r_out, m_in, m_out, done;
    logic [W-1:0] d_in, d_out;
    logic [W-1:0] res [2*N];

    gray_conv_pipe #(.WIDTH(W), .STAGES(S)) u_rt (
      .clk       (clk),
      .rst_n     (rt_rst_n),
      .clr       (1'b0),
      .in_valid  (v_in),
      .in_ready  (r_in),
      .in_data   (d_in),
      .in_mode   (m_in),
      .out_valid (v_out),
      .out_ready (r_out),
      .out_data  (d_out),
      .out_mode  (m_out)
    );

    assign rt_done[gi] = done;

    initial begin
      int           idx, k;
      logic [W-1:0] ones, expd;
      logic         lv [9];
      logic [W-1:0] ld [9];
      logic         lm [9];
      logic [15:0]  g;
      done  = 1'b0;
      v_in  = 1'b0;
      m_in  = 1'b0;
      d_in  = '0;
      r_out = 1'b1;
      ones  = '1;
      wait (rt_go);
      @(posedge clk);
      #1;
      // Latency pins: all-ones Gray -> alternating binary, and back.
      for (int j = 0; j < 2; j++) begin
        v_in = 1'b1;
        m_in = (j == 0);
        d_in = (j == 0) ? ones : LIT;
        expd = (j == 0) ? LIT : ones;
        @(negedge clk);
        lv[0] = v_out; ld[0] = d_out; lm[0] = m_out;
        @(posedge clk);
        #1;
        v_in = 1'b0;
        for (int c = 1; c <= S; c++) begin
          @(negedge clk);
          lv[c] = v_out; ld[c] = d_out; lm[c] = m_out;
        end
        check($sformatf("rt%0d_lat_early%0d", gi, j), lv[S-1], 1'b0);
        check($sformatf("rt%0d_lat_valid%0d", gi, j), lv[S], 1'b1);
        check($sformatf("rt%0d_lat_data%0d", gi, j), ld[S], expd);
        check($sformatf("rt%0d_lat_mode%0d", gi, j), lm[S], (j == 0));
        @(posedge clk);
        #1;
      end
      // Every value to Gray, then every Gray result back to binary.
      idx = 0;
      k   = 0;
      for (int c = 0; c < 4 * N + 200 && k < 2 * N; c++) begin
        v_in = (idx < 2 * N);
        m_in = (idx >= N);
        if (idx < N) d_in = idx[W-1:0];
        else         d_in = res[idx-N];
        r_out = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (v_out && r_out) begin
          check($sformatf("rt%0d_mode_k%0d", gi, k), m_out, (k >= N));
          res[k] = d_out;
          k++;
        end
        if (v_in && r_in) idx++;
        @(posedge clk);
        #1;
      end
      v_in = 1'b0;
      check($sformatf("rt%0d_complete", gi), k, 2 * N);
      for (int v = 0; v < N; v++) begin
        g = model(16'(v), 1'b0, W);
        check($sformatf("rt%0d_gray_v%0d", gi, v), res[v], g[W-1:0]);
        check($sformatf("rt%0d_round_v%0d", gi, v), res[N+v], v[W-1:0]);
        if (v < N - 1) begin
          check($sformatf("rt%0d_adj_v%0d", gi, v), $countones(res[v] ^ res[v+1]), 1);
        end
      end
      done = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int             idx;
    int             t;
    logic           bv [10];
    logic           br [10];
    logic [M_W-1:0] bd [10];
    int             bi [10];
    logic [M_W-1:0] bp_w [3];

    rst_n = 1'b0; rt_rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0;
    in_data = '0; in_mode = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_mode", out_mode, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1; rt_rst_n = 1'b1; rt_go = 1'b1;

    // Single words in both directions.
    bw_data[0] = 8'h2D; bw_mode[0] = 1'b0; bw_exp[0] = 8'h3B; run_burst(1, "b2g_2d");
    bw_data[0] = 8'hFF; bw_mode[0] = 1'b0; bw_exp[0] = 8'h80; run_burst(1, "b2g_ff");
    bw_data[0] = 8'h00; bw_mode[0] = 1'b0; bw_exp[0] = 8'h00; run_burst(1, "b2g_00");
    bw_data[0] = 8'h3B; bw_mode[0] = 1'b1; bw_exp[0] = 8'h2D; run_burst(1, "g2b_3b");
    bw_data[0] = 8'h80; bw_mode[0] = 1'b1; bw_exp[0] = 8'hFF; run_burst(1, "g2b_80");

    // Interleaved modes back to back.
    bw_data[0] = 8'h2D; bw_mode[0] = 1'b0; bw_exp[0] = 8'h3B;
    bw_data[1] = 8'h3B; bw_mode[1] = 1'b1; bw_exp[1] = 8'h2D;
    bw_data[2] = 8'hA5; bw_mode[2] = 1'b0; bw_exp[2] = 8'hF7;
    bw_data[3] = 8'hF7; bw_mode[3] = 1'b1; bw_exp[3] = 8'hA5;
    run_burst(4, "mix");

    // Backpressure: out_ready low for 5 cycles while streaming 3 words.
    bp_w[0] = 8'h2D; bp_w[1] = 8'hFF; bp_w[2] = 8'h00;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid  = (idx < 3);
      in_data   = (idx < 3) ? bp_w[idx] : 8'h00;
      in_mode   = 1'b0;
      out_ready = (c >= 5);
      @(negedge clk);
      bv[c] = out_valid; br[c] = in_ready; bd[c] = out_data; bi[c] = idx;
      if (in_valid && in_ready) idx++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("bp_accepts_before_full", bi[2], 2);
    check("bp_full_in_ready", br[2], 1'b0);
    for (int c = 2; c < 5; c++) begin
      check($sformatf("bp_hold_valid_c%0d", c), bv[c], 1'b1);
      check($sformatf("bp_hold_data_c%0d", c), bd[c], 8'h3B);
    end
    check("bp_rel_w0", {bv[5], bd[5]}, {1'b1, 8'h3B});
    check("bp_rel_w1", {bv[6], bd[6]}, {1'b1, 8'h80});
    check("bp_rel_w2", {bv[7], bd[7]}, {1'b1, 8'h00});
    check("bp_empty", bv[8], 1'b0);

    // Flush a full pipeline; the word presented during clr is not captured.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h11; in_mode = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    clr = 1'b1; in_data = 8'h22;
    @(negedge clk);
    check("clr_pre_valid", out_valid, 1'b1);
    check("clr_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1;
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("flush_no_stale_c%0d", c), out_valid, 1'b0);
    end
    @(posedge clk);
    #1;

    // Asynchronous reset mid-cycle with a full pipeline.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h5A; in_mode = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_out_data", out_data, 8'h00);
    check("arst_out_mode", out_mode, 1'b0);
    check("arst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bw_data[0] = 8'h2D; bw_mode[0] = 1'b0; bw_exp[0] = 8'h3B; run_burst(1, "post_rst");

    // Randomized traffic with stalls, flushes and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      in_mode   = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      clr       = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 399) == 0) begin
        #3;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0; clr = 1'b0; out_ready = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    @(negedge clk);
    check("drain_empty", q.size(), 0);

    t = 0;
    while (rt_done !== {NCFG{1'b1}} && t < 60000) begin
      @(posedge clk);
      t++;
    end
    check("rt_all_done", rt_done, {NCFG{1'b1}});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
